// File: rtl/maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// maze_game_ctrl : carve handshake, player movement and win detection for a 16x16 maze
// Revision 1.0
// ============================================================================
module maze_game_ctrl #(
   parameter logic [25:0] SPEED1 = 26'd1000,
   parameter logic [25:0] SPEED2 = 26'd100000,
   parameter logic [25:0] SPEED3 = 26'd5000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         btn_new,
   input  logic         btn_up,
   input  logic         btn_left,
   input  logic         btn_down,
   input  logic         btn_right,
   input  logic [1:0]   speed_sel,
   input  logic         carve_finish,
   input  logic [3:0]   carve_goal_x,
   input  logic [3:0]   carve_goal_y,
   input  logic [255:0] maze_data,
   output logic         carve_start,
   output logic [25:0]  carve_slow_time,
   output logic [3:0]   player_x,
   output logic [3:0]   player_y,
   output logic [3:0]   goal_x,
   output logic [3:0]   goal_y,
   output logic [2:0]   state,
   output logic         win,
   output logic [9:0]   move_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_ARM   = 3'd2,
      S_CARVE = 3'd3,
      S_PLAY  = 3'd4,
      S_WON   = 3'd5
   } state_t;

   localparam logic [3:0] ARM_LAST = 4'd15;
   localparam logic [9:0] MOVE_MAX = 10'd1023;

   state_t      state_q, state_d;
   logic        carve_start_q, carve_start_d;
   logic [25:0] slow_time_q, slow_time_d;
   logic [3:0]  player_x_q, player_x_d;
   logic [3:0]  player_y_q, player_y_d;
   logic [3:0]  goal_x_q, goal_x_d;
   logic [3:0]  goal_y_q, goal_y_d;
   logic        win_q, win_d;
   logic [9:0]  move_count_q, move_count_d;
   logic [3:0]  arm_cnt_q, arm_cnt_d;

   logic [25:0] speed_val;
   logic [4:0]  tgt_x, tgt_y;
   logic        move_req;
   logic        move_ok;
   logic        at_goal;

   always_comb begin
      speed_val = 26'd0;
      case (speed_sel)
         2'd1:    speed_val = SPEED1;
         2'd2:    speed_val = SPEED2;
         2'd3:    speed_val = SPEED3;
         default: speed_val = 26'd0;
      endcase
   end

   // Only the highest-priority pulse produces a target; the rest are dropped.
   // A 5-bit target with bit 4 set means the move fell off the board.
   always_comb begin
      tgt_x    = {1'b0, player_x_q};
      tgt_y    = {1'b0, player_y_q};
      move_req = 1'b1;
      if (btn_up) begin
         tgt_y = {1'b0, player_y_q} - 5'd1;
      end else if (btn_left) begin
         tgt_x = {1'b0, player_x_q} - 5'd1;
      end else if (btn_down) begin
         tgt_y = {1'b0, player_y_q} + 5'd1;
      end else if (btn_right) begin
         tgt_x = {1'b0, player_x_q} + 5'd1;
      end else begin
         move_req = 1'b0;
      end
      move_ok = move_req && !tgt_x[4] && !tgt_y[4]
                && maze_data[{tgt_y[3:0], tgt_x[3:0]}];
   end

   assign at_goal = (player_x_q == goal_x_q) && (player_y_q == goal_y_q);

   always_comb begin
      state_d      = state_q;
      slow_time_d  = slow_time_q;
      player_x_d   = player_x_q;
      player_y_d   = player_y_q;
      goal_x_d     = goal_x_q;
      goal_y_d     = goal_y_q;
      move_count_d = move_count_q;
      arm_cnt_d    = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (btn_new) state_d = S_START;
         end
         S_START: begin
            state_d = S_ARM;
         end
         S_ARM: begin
            if (!carve_finish) begin
               state_d = S_CARVE;
            end else if (arm_cnt_q == ARM_LAST) begin
               state_d = S_START;
            end else begin
               arm_cnt_d = arm_cnt_q + 4'd1;
            end
         end
         S_CARVE: begin
            if (carve_finish) begin
               state_d  = S_PLAY;
               goal_x_d = carve_goal_x;
               goal_y_d = carve_goal_y;
            end
         end
         S_PLAY: begin
            if (btn_new) begin
               state_d = S_START;
            end else if (at_goal) begin
               state_d = S_WON;
            end else if (move_ok) begin
               player_x_d = tgt_x[3:0];
               player_y_d = tgt_y[3:0];
               if (move_count_q != MOVE_MAX) move_count_d = move_count_q + 10'd1;
            end
         end
         S_WON: begin
            if (btn_new) state_d = S_START;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every way into START begins a fresh game with a freshly sampled speed.
      if (state_d == S_START) begin
         slow_time_d  = speed_val;
         player_x_d   = 4'd0;
         player_y_d   = 4'd0;
         move_count_d = 10'd0;
      end

      carve_start_d = (state_d == S_START);
      win_d         = (state_d == S_WON);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         carve_start_q <= 1'b0;
         slow_time_q   <= 26'd0;
         player_x_q    <= 4'd0;
         player_y_q    <= 4'd0;
         goal_x_q      <= 4'd0;
         goal_y_q      <= 4'd0;
         win_q         <= 1'b0;
         move_count_q  <= 10'd0;
         arm_cnt_q     <= 4'd0;
      end else begin
         state_q       <= state_d;
         carve_start_q <= carve_start_d;
         slow_time_q   <= slow_time_d;
         player_x_q    <= player_x_d;
         player_y_q    <= player_y_d;
         goal_x_q      <= goal_x_d;
         goal_y_q      <= goal_y_d;
         win_q         <= win_d;
         move_count_q  <= move_count_d;
         arm_cnt_q     <= arm_cnt_d;
      end
   end

   assign carve_start     = carve_start_q;
   assign carve_slow_time = slow_time_q;
   assign player_x        = player_x_q;
   assign player_y        = player_y_q;
   assign goal_x          = goal_x_q;
   assign goal_y          = goal_y_q;
   assign state           = state_q;
   assign win             = win_q;
   assign move_count      = move_count_q;

endmodule
`default_nettype wire
